// File: rtl/spi_cmd_master.sv
// spi_cmd_master
// Host-side SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// Takes parallel command words over a valid/ready handshake, shifts them out
// on MOSI and returns the word captured on MISO as a one-cycle response
// pulse. Setting cmd_hold with a word keeps SS low so that the next word
// continues the same frame.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   cmd_valid  command word valid
//   cmd_ready  master can accept a command word (IDLE and CHAIN only)
//   cmd_data   word to transmit, MSB first
//   cmd_hold   sampled with cmd_data; 1 keeps SS low after this word
//   rsp_valid  one-cycle pulse, rsp_data valid
//   rsp_data   word captured from MISO, held until the next rsp_valid
//   busy       high whenever the FSM is not in IDLE
//   SCLK       SPI clock
//   MOSI       SPI data out
//   SS         active-low slave select
//   MISO       SPI data in
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | SS high, cmd_ready high, waiting for a command word
// SETUP | SS low, SCLK low, first bit on MOSI; CLK_DIV cycles
// SHIFT | DATA_W bit periods of CLK_DIV low + CLK_DIV high SCLK cycles
// HOLD  | SS low, SCLK low after the last falling edge; CLK_DIV cycles
// GAP   | SS high between frames; GAP_CYC cycles
// CHAIN | SS kept low, cmd_ready high, waiting for the next word of frame

module spi_cmd_master #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_hold,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SCLK,
  output logic              MOSI,
  output logic              SS,
  input  logic              MISO
);

  localparam int DIV_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int BIT_W   = $clog2(DATA_W + 1);

  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_TC   = DIV_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP,
    S_CHAIN
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  // Only the bits still to be sent are kept; the current bit lives in r_mosi.
  logic [DATA_W-2:0] r_sh;
  logic [DATA_W-1:0] r_rx;
  logic              r_hold;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_busy;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_ss;

  logic              w_div_tc_bit;
  logic              w_div_tc_gap;
  logic              w_accept;

  assign w_div_tc_bit = (r_div == DIV_TC);
  assign w_div_tc_gap = (r_div == GAP_TC);
  assign w_accept     = cmd_valid && r_cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_sh        <= '0;
      r_rx        <= '0;
      r_hold      <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_ss        <= 1'b1;
    end else begin
      r_rsp_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sh        <= cmd_data[DATA_W-2:0];
            r_mosi      <= cmd_data[DATA_W-1];
            r_hold      <= cmd_hold;
            r_cmd_ready <= 1'b0;
            r_ss        <= 1'b0;
            r_sclk      <= 1'b0;
            r_busy      <= 1'b1;
            r_div       <= '0;
            r_bit       <= '0;
            r_state     <= S_SETUP;
          end else begin
            // Also raises ready on the first edge after reset release.
            r_cmd_ready <= 1'b1;
          end
        end

        S_SETUP: begin
          if (w_div_tc_bit) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        S_SHIFT: begin
          if (w_div_tc_bit) begin
            r_div <= '0;
            if (!r_sclk) begin
              // Rising edge: capture MISO.
              r_sclk <= 1'b1;
              r_rx   <= {r_rx[DATA_W-2:0], MISO};
            end else begin
              // Falling edge: advance MOSI unless this closed the last bit,
              // in which case MOSI keeps the last bit through HOLD.
              r_sclk <= 1'b0;
              if (r_bit == BIT_LAST) begin
                r_bit   <= '0;
                r_state <= S_HOLD;
              end else begin
                r_bit  <= r_bit + BIT_W'(1);
                r_mosi <= r_sh[DATA_W-2];
                r_sh   <= {r_sh[DATA_W-3:0], 1'b0};
              end
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        S_HOLD: begin
          if (w_div_tc_bit) begin
            r_div       <= '0;
            r_bit       <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_rx;
            if (r_hold) begin
              r_cmd_ready <= 1'b1;
              r_state     <= S_CHAIN;
            end else begin
              r_ss    <= 1'b1;
              r_state <= S_GAP;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        S_GAP: begin
          if (w_div_tc_gap) begin
            r_div       <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        S_CHAIN: begin
          // No SETUP here: SS is already low and the first bit goes out
          // on the accepting edge.
          if (w_accept) begin
            r_sh        <= cmd_data[DATA_W-2:0];
            r_mosi      <= cmd_data[DATA_W-1];
            r_hold      <= cmd_hold;
            r_cmd_ready <= 1'b0;
            r_div       <= '0;
            r_bit       <= '0;
            r_state     <= S_SHIFT;
          end
        end

        default: begin
          r_ss        <= 1'b1;
          r_sclk      <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_busy      <= 1'b0;
          r_div       <= '0;
          r_bit       <= '0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;
  assign SCLK      = r_sclk;
  assign MOSI      = r_mosi;
  assign SS        = r_ss;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Testbench for spi_cmd_master with default parameters.
// A negedge monitor numbers cycles and logs SCLK rises, MOSI per rise, SS
// edges and responses; an optional slave model shifts a fixed word out on
// MISO, otherwise MISO is looped back from MOSI.

module tb_spi_cmd_master;

  localparam int DW = 16;
  localparam int CD = 2;
  localparam int GC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_data;
  logic          cmd_hold;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          SCLK;
  logic          MOSI;
  logic          SS;
  logic          MISO;

  always #5 clk = ~clk;

  spi_cmd_master #(
    .DATA_W (DW),
    .CLK_DIV(CD),
    .GAP_CYC(GC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .cmd_hold (cmd_hold),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .SS       (SS),
    .MISO     (MISO)
  );

  int checks   = 0;
  int failures = 0;

  // Monitor state
  int            cyc = 0;
  int            rise_cnt = 0;
  int            rsp_cnt = 0;
  int            ss_rise_cnt = 0;
  int            mosi_bad = 0;
  int            mosi_tog = 0;
  int            ss_fall_cyc = 0;
  int            ss_rise_cyc = 0;
  int            ready_rise_cyc = 0;
  int            rsp_cyc = 0;
  int            last_gap = 0;
  int            ss_high_run = 0;
  int            rise_log[$];
  logic [DW-1:0] rsp_log[$];
  logic [63:0]   mosi_hist = '0;
  logic          p_sclk = 1'b0;
  logic          p_mosi = 1'b0;
  logic          p_ss = 1'b1;
  logic          p_ready = 1'b0;
  logic          tb_loop = 1'b1;
  logic [DW-1:0] slave_word = '0;
  logic [DW-1:0] slv_sh = '0;

  assign MISO = tb_loop ? MOSI : slv_sh[DW-1];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (SCLK && !p_sclk) begin
      rise_cnt = rise_cnt + 1;
      rise_log.push_back(cyc);
      mosi_hist = {mosi_hist[62:0], MOSI};
    end
    if (!SCLK && p_sclk && !SS) slv_sh = {slv_sh[DW-2:0], 1'b0};
    if ((MOSI != p_mosi) && SCLK) mosi_bad = mosi_bad + 1;
    if ((MOSI != p_mosi) && !SS && !p_ss) mosi_tog = mosi_tog + 1;
    if (!SS && p_ss) begin
      ss_fall_cyc = cyc;
      last_gap    = ss_high_run;
      slv_sh      = slave_word;
    end
    if (SS && !p_ss) begin
      ss_rise_cnt = ss_rise_cnt + 1;
      ss_rise_cyc = cyc;
    end
    if (SS) ss_high_run = ss_high_run + 1;
    else    ss_high_run = 0;
    if (cmd_ready && !p_ready) ready_rise_cyc = cyc;
    if (rsp_valid) begin
      rsp_cnt = rsp_cnt + 1;
      rsp_cyc = cyc;
      rsp_log.push_back(rsp_data);
    end
    p_sclk  = SCLK;
    p_mosi  = MOSI;
    p_ss    = SS;
    p_ready = cmd_ready;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Presents a word from just after a negedge; hs is the cycle in which
  // valid and ready were both high (accepted on the following posedge).
  task automatic send(input logic [DW-1:0] d, input logic h, input logic keep, output int hs);
    int n;
    @(negedge clk); #1;
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_hold  = h;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL send_timeout actual=ready_low expected=ready_high");
    end
    hs = cyc;
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (!(rsp_cnt >= target && cmd_ready) && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (!(rsp_cnt >= target && cmd_ready)) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL done_timeout actual_rsp=%0d expected_rsp=%0d", rsp_cnt, target);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          loop;
    logic [DW-1:0] slave;
    logic [DW-1:0] exp_rsp;
    int            exp_tog;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int hs, hs2, n, r0, b0, bad0, tog0, s0, nfall;

    // data, loopback, slave word, expected rsp, MOSI toggles while SS low
    vecs[0] = '{16'hA55A, 1'b1, 16'h0000, 16'hA55A, 13};
    vecs[1] = '{16'hFFFF, 1'b0, 16'h3C0F, 16'h3C0F, 0};
    vecs[2] = '{16'h0000, 1'b0, 16'hFFFF, 16'hFFFF, 0};
    vecs[3] = '{16'h8001, 1'b1, 16'h0000, 16'h8001, 2};

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_hold  = 1'b0;

    // Reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_outputs", {58'd0, SS, SCLK, MOSI, rsp_valid, cmd_ready, busy}, 64'b100000);
    end
    chk("reset_rsp_data", rsp_data, 0);
    #1 rst = 1'b1;
    #1 chk("ready_before_edge", cmd_ready, 0);
    @(negedge clk);
    chk("ready_after_release", cmd_ready, 1);
    chk("busy_idle", busy, 0);

    // Single-word frames from the table; N = first cycle with SS low.
    for (int i = 0; i < 4; i++) begin
      tb_loop    = vecs[i].loop;
      slave_word = vecs[i].slave;
      r0   = rise_cnt;
      b0   = rsp_cnt;
      bad0 = mosi_bad;
      tog0 = mosi_tog;
      s0   = ss_rise_cnt;
      send(vecs[i].data, 1'b0, 1'b0, hs);
      #1 chk("busy_after_accept", busy, 1);
      wait_done(b0 + 1);
      nfall = ss_fall_cyc;
      chk("ss_fall_after_hs", nfall - hs, 1);
      chk("rise_count", rise_cnt - r0, 16);
      chk("first_rise_cyc", rise_log[r0] - nfall, 4);
      chk("last_rise_cyc", rise_log[r0 + 15] - nfall, 64);
      chk("rsp_cyc", rsp_cyc - nfall, 68);
      chk("ss_rise_cyc", ss_rise_cyc - nfall, 68);
      chk("ss_rise_count", ss_rise_cnt - s0, 1);
      chk("ready_rise_cyc", ready_rise_cyc - nfall, 70);
      chk("rsp_count", rsp_cnt - b0, 1);
      chk("rsp_data", rsp_data, vecs[i].exp_rsp);
      chk("mosi_bits", mosi_hist[15:0], vecs[i].data);
      chk("mosi_stable_sclk_high", mosi_bad - bad0, 0);
      chk("mosi_toggles", mosi_tog - tog0, vecs[i].exp_tog);
      chk("busy_back_idle", busy, 0);
    end

    // Chained frame: SS must stay low across both words.
    tb_loop = 1'b1;
    r0 = rise_cnt;
    b0 = rsp_cnt;
    s0 = ss_rise_cnt;
    send(16'h1234, 1'b1, 1'b0, hs);
    n = 0;
    while (rsp_cnt < b0 + 1 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("chain_first_rsp", rsp_cnt - b0, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
    end
    #1;
    chk("chain_wait_state", {60'd0, SS, SCLK, cmd_ready, busy}, 64'b0011);
    send(16'hBEEF, 1'b0, 1'b0, hs2);
    wait_done(b0 + 2);
    chk("chain_rsp_count", rsp_cnt - b0, 2);
    chk("chain_rsp0", rsp_log[b0], 16'h1234);
    chk("chain_rsp1", rsp_log[b0 + 1], 16'hBEEF);
    chk("chain_rise_count", rise_cnt - r0, 32);
    chk("chain_ss_rises", ss_rise_cnt - s0, 1);
    // Accepted at the end of cycle hs2; two SCLK-low cycles, then the rise.
    chk("chain_no_setup", rise_log[r0 + 16] - hs2, 3);
    chk("chain_mosi_bits", mosi_hist[31:0], {16'h1234, 16'hBEEF});

    // Backpressure: valid held high across two words.
    b0 = rsp_cnt;
    send(16'h0001, 1'b0, 1'b1, hs);
    send(16'h0002, 1'b0, 1'b0, hs2);
    wait_done(b0 + 2);
    chk("bp_second_accept", hs2 - hs, 71);
    chk("bp_gap", last_gap, 3);
    chk("bp_rsp0", rsp_log[b0], 16'h0001);
    chk("bp_rsp1", rsp_log[b0 + 1], 16'h0002);

    // Reset in the middle of SHIFT.
    r0 = rise_cnt;
    b0 = rsp_cnt;
    send(16'h5A5A, 1'b0, 1'b0, hs);
    n = 0;
    while (rise_cnt < r0 + 5 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("mid_sclk_high", SCLK, 1);
    rst = 1'b0;
    #1;
    chk("mid_reset_pins", {61'd0, SS, SCLK, busy}, 64'b100);
    chk("mid_reset_ready", cmd_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
    end
    #1 rst = 1'b1;
    wait_done(b0);
    chk("mid_no_rsp", rsp_cnt - b0, 0);
    chk("mid_rsp_data_cleared", rsp_data, 0);
    send(16'h00FF, 1'b0, 1'b0, hs);
    wait_done(b0 + 1);
    chk("post_reset_rsp_count", rsp_cnt - b0, 1);
    chk("post_reset_rsp", rsp_data, 16'h00FF);
    chk("post_reset_mosi", mosi_hist[15:0], 16'h00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
